// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a 2R1W register file.
// Round-robin with lockable bursts; drives the rf ports, returns rvalid.
module regfile_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_lock,
  input  logic              b_lock,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [ADDR_W-1:0] b_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [ADDR_W-1:0] a_raddr1,
  input  logic [ADDR_W-1:0] a_raddr2,
  input  logic [ADDR_W-1:0] b_raddr1,
  input  logic [ADDR_W-1:0] b_raddr2,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] rf_read_address_1,
  output logic [ADDR_W-1:0] rf_read_address_2,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  input  logic [DATA_W-1:0] rf_data_out_1,
  input  logic [DATA_W-1:0] rf_data_out_2
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // The opening grant of a burst is issued from IDLE, so the
  // owned state may add at most MAX_BURST-1 further grants.
  localparam logic [CNT_W-1:0] OWN_LAST = CNT_W'(MAX_BURST - 1);
  localparam bit CAN_LOCK = (MAX_BURST > 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr_b;
  logic             ptr_b_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             burst_last;
  logic             gnt_a;
  logic             gnt_b;

  // Saturating so the counter can never wrap.
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
  assign burst_last = (cnt_inc >= OWN_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr_b <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr_b <= ptr_b_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_b_nxt = ptr_b;
    cnt_nxt   = cnt;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req && (!b_req || !ptr_b)) begin
          gnt_a = 1'b1;
        end else if (b_req) begin
          gnt_b = 1'b1;
        end
        if (gnt_a) begin
          ptr_b_nxt = 1'b1;
          if (a_lock && CAN_LOCK) begin
            state_nxt = OWN_A;
            cnt_nxt   = '0;
          end
        end
        if (gnt_b) begin
          ptr_b_nxt = 1'b0;
          if (b_lock && CAN_LOCK) begin
            state_nxt = OWN_B;
            cnt_nxt   = '0;
          end
        end
      end
      OWN_A: begin
        gnt_a = a_req;
        if (a_req) begin
          cnt_nxt = cnt_inc;
        end
        if (!a_req || !a_lock || burst_last) begin
          state_nxt = IDLE;
          ptr_b_nxt = 1'b1;
        end
      end
      OWN_B: begin
        gnt_b = b_req;
        if (b_req) begin
          cnt_nxt = cnt_inc;
        end
        if (!b_req || !b_lock || burst_last) begin
          state_nxt = IDLE;
          ptr_b_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grants are forced low while reset is held, even though the
  // state register is already at IDLE.
  assign a_gnt = gnt_a & ~reset;
  assign b_gnt = gnt_b & ~reset;

  always_comb begin
    rf_read_address_1 = '0;
    rf_read_address_2 = '0;
    rf_write_address  = '0;
    rf_write_data     = '0;
    rf_write_enable   = 1'b0;
    unique case (1'b1)
      a_gnt: begin
        rf_read_address_1 = a_raddr1;
        rf_read_address_2 = a_raddr2;
        rf_write_address  = a_waddr;
        rf_write_data     = a_wdata;
        rf_write_enable   = a_we & (a_waddr != '0);
      end
      b_gnt: begin
        rf_read_address_1 = b_raddr1;
        rf_read_address_2 = b_raddr2;
        rf_write_address  = b_waddr;
        rf_write_data     = b_wdata;
        rf_write_enable   = b_we & (b_waddr != '0);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt;
      b_rvalid <= b_gnt;
    end
  end

  assign rdata1 = rf_data_out_1;
  assign rdata2 = rf_data_out_2;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic
// against a transaction-level arbitration and register file model.
module tb_regfile_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, b_req, a_lock, b_lock, a_we, b_we;
  logic [AW-1:0] a_waddr, b_waddr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [AW-1:0] a_raddr1, a_raddr2, b_raddr1, b_raddr2;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] rdata1, rdata2;
  logic [AW-1:0] rf_read_address_1, rf_read_address_2, rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic          rf_write_enable;
  logic [DW-1:0] rf_data_out_1, rf_data_out_2;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_BURST(MB)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .a_req            (a_req),
    .b_req            (b_req),
    .a_lock           (a_lock),
    .b_lock           (b_lock),
    .a_we             (a_we),
    .b_we             (b_we),
    .a_waddr          (a_waddr),
    .b_waddr          (b_waddr),
    .a_wdata          (a_wdata),
    .b_wdata          (b_wdata),
    .a_raddr1         (a_raddr1),
    .a_raddr2         (a_raddr2),
    .b_raddr1         (b_raddr1),
    .b_raddr2         (b_raddr2),
    .a_gnt            (a_gnt),
    .b_gnt            (b_gnt),
    .a_rvalid         (a_rvalid),
    .b_rvalid         (b_rvalid),
    .rdata1           (rdata1),
    .rdata2           (rdata2),
    .rf_read_address_1(rf_read_address_1),
    .rf_read_address_2(rf_read_address_2),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_enable  (rf_write_enable),
    .rf_data_out_1    (rf_data_out_1),
    .rf_data_out_2    (rf_data_out_2)
  );

  always #5 clock = ~clock;

  // Register file stub: registered reads, read-before-write, reg i = i.
  logic [DW-1:0] rf_mem [32];
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] <= DW'(i);
  end
  always @(posedge clock) begin
    if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_data;
    rf_data_out_1 <= rf_mem[rf_read_address_1];
    rf_data_out_2 <= rf_mem[rf_read_address_2];
  end

  // Reference model: who holds a burst, how long, whose turn it is.
  logic [DW-1:0] ref_mem [32];
  int            m_holder;
  int            m_held;
  int            m_turn;
  logic          exp_av, exp_bv;
  logic [DW-1:0] exp_r1, exp_r2;

  task automatic model_reset();
    m_holder = 0;
    m_held   = 0;
    m_turn   = 1;
    exp_av   = 1'b0;
    exp_bv   = 1'b0;
  endtask

  function automatic int exp_grant();
    if (m_holder == 1) return a_req ? 1 : 0;
    if (m_holder == 2) return b_req ? 2 : 0;
    if (a_req && b_req) return m_turn;
    if (a_req) return 1;
    if (b_req) return 2;
    return 0;
  endfunction

  task automatic advance(input int g);
    logic [AW-1:0] r1, r2, wa;
    logic [DW-1:0] wd;
    logic          we, lk;
    r1 = '0; r2 = '0; wa = '0; wd = '0; we = 1'b0; lk = 1'b0;
    if (g == 1) begin
      r1 = a_raddr1; r2 = a_raddr2; wa = a_waddr;
      wd = a_wdata; we = a_we; lk = a_lock;
    end else if (g == 2) begin
      r1 = b_raddr1; r2 = b_raddr2; wa = b_waddr;
      wd = b_wdata; we = b_we; lk = b_lock;
    end
    @(posedge clock);
    exp_av = (g == 1);
    exp_bv = (g == 2);
    exp_r1 = ref_mem[r1];
    exp_r2 = ref_mem[r2];
    if (g != 0 && we && wa != 0) ref_mem[wa] = wd;
    if (g == 0) begin
      if (m_holder != 0) begin
        m_turn   = 3 - m_holder;
        m_holder = 0;
      end
    end else begin
      m_held = (m_holder == g) ? m_held + 1 : 1;
      if (lk && m_held < MB) begin
        m_holder = g;
      end else begin
        m_holder = 0;
        m_turn   = 3 - g;
      end
    end
  endtask

  task automatic zero_inputs();
    a_req = 0; b_req = 0; a_lock = 0; b_lock = 0; a_we = 0; b_we = 0;
    a_waddr = '0; b_waddr = '0; a_wdata = '0; b_wdata = '0;
    a_raddr1 = '0; a_raddr2 = '0; b_raddr1 = '0; b_raddr2 = '0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    zero_inputs();
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    advance(exp_grant());
  endtask

  task automatic test_reset();
    zero_inputs();
    reset = 1'b1;
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    a_waddr = 5'd3; b_waddr = 5'd4;
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_gnt got=%b exp=00", {a_gnt, b_gnt});
    end
    n_cmp++;
    if (rf_write_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_we got=%b exp=0", rf_write_enable);
    end
    n_cmp++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_rvalid got=%b exp=00", {a_rvalid, b_rvalid});
    end
    model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = DW'(i);
    @(negedge clock);
    reset = 1'b0;
    zero_inputs();
    advance(exp_grant());
  endtask

  task automatic test_single_read();
    @(negedge clock);
    a_req = 1; a_raddr1 = 5'd7; a_raddr2 = 5'd31;
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_gnt got=%b exp=10", {a_gnt, b_gnt});
    end
    advance(exp_grant());
    @(negedge clock);
    zero_inputs();
    #1;
    n_cmp++;
    if ({a_rvalid, b_rvalid, rdata1, rdata2} !== {2'b10, 32'd7, 32'd31}) begin
      n_bad++;
      $display("FAIL single_read got=%b/%0d/%0d exp=10/7/31",
               {a_rvalid, b_rvalid}, rdata1, rdata2);
    end
    advance(exp_grant());
  endtask

  task automatic test_round_robin();
    logic [1:0] prev;
    apply_reset();
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      a_req = 1; b_req = 1;
      a_raddr1 = AW'($urandom); b_raddr1 = AW'($urandom);
      #1;
      n_cmp++;
      if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL rr_gnt i=%0d got=%b", i, {a_gnt, b_gnt});
      end
      n_cmp++;
      if ({a_rvalid, b_rvalid} !== prev) begin
        n_bad++;
        $display("FAIL rr_rvalid i=%0d got=%b exp=%b", i,
                 {a_rvalid, b_rvalid}, prev);
      end
      prev = (i % 2 == 0) ? 2'b10 : 2'b01;
      advance(exp_grant());
    end
    @(negedge clock);
    zero_inputs();
    advance(exp_grant());
  endtask

  task automatic test_burst_limit();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      a_req = 1; a_lock = 1; b_req = 1;
      #1;
      n_cmp++;
      if ({a_gnt, b_gnt} !== ((i == MB) ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL burst_gnt i=%0d got=%b", i, {a_gnt, b_gnt});
      end
      advance(exp_grant());
    end
    @(negedge clock);
    zero_inputs();
    advance(exp_grant());
  endtask

  task automatic test_zero_write();
    @(negedge clock);
    zero_inputs();
    b_req = 1; b_we = 1; b_waddr = '0; b_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({b_gnt, rf_write_enable} !== 2'b10) begin
      n_bad++;
      $display("FAIL zero_wr got=%b exp=10", {b_gnt, rf_write_enable});
    end
    advance(exp_grant());
    @(negedge clock);
    zero_inputs();
    b_req = 1; b_raddr1 = '0;
    #1;
    advance(exp_grant());
    @(negedge clock);
    zero_inputs();
    #1;
    n_cmp++;
    if ({b_rvalid, rdata1} !== {1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL zero_rd got=%b/%h exp=1/0", b_rvalid, rdata1);
    end
    advance(exp_grant());
  endtask

  task automatic test_read_before_write();
    @(negedge clock);
    zero_inputs();
    a_req = 1; a_we = 1; a_waddr = 5'd5; a_wdata = 32'h1234;
    a_raddr1 = 5'd5;
    #1;
    n_cmp++;
    if ({a_gnt, rf_write_enable, rf_write_address} !== {2'b11, 5'd5}) begin
      n_bad++;
      $display("FAIL rbw_wr got=%b/%b/%0d exp=1/1/5",
               a_gnt, rf_write_enable, rf_write_address);
    end
    advance(exp_grant());
    @(negedge clock);
    zero_inputs();
    a_req = 1; a_raddr1 = 5'd5;
    #1;
    n_cmp++;
    if (rdata1 !== 32'd5) begin
      n_bad++;
      $display("FAIL rbw_old got=%h exp=5", rdata1);
    end
    advance(exp_grant());
    @(negedge clock);
    zero_inputs();
    #1;
    n_cmp++;
    if (rdata1 !== 32'h1234) begin
      n_bad++;
      $display("FAIL rbw_new got=%h exp=1234", rdata1);
    end
    advance(exp_grant());
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      a_req = 1; a_lock = 1;
      #1;
      n_cmp++;
      if (a_gnt !== 1'b1) begin
        n_bad++;
        $display("FAIL rstb_pre i=%0d got=%b exp=1", i, a_gnt);
      end
      if (i < 2) advance(exp_grant());
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rstb_drop got=%b exp=0000",
               {a_gnt, b_gnt, a_rvalid, b_rvalid});
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    zero_inputs();
    b_req = 1;
    #1;
    n_cmp++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0100) begin
      n_bad++;
      $display("FAIL rstb_after got=%b exp=0100",
               {a_gnt, b_gnt, a_rvalid, b_rvalid});
    end
    advance(exp_grant());
    @(negedge clock);
    zero_inputs();
    advance(exp_grant());
  endtask

  task automatic test_random();
    int            g;
    logic [1:0]    eg;
    logic [AW-1:0] e1, e2, ew;
    logic [DW-1:0] ed;
    logic          ewe;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      a_req = ($urandom_range(0, 3) != 0);
      b_req = ($urandom_range(0, 3) != 0);
      a_lock = $urandom_range(0, 1) == 1;
      b_lock = $urandom_range(0, 2) == 0;
      a_we = $urandom_range(0, 1) == 1;
      b_we = $urandom_range(0, 1) == 1;
      a_waddr = AW'($urandom_range(0, 7));
      b_waddr = AW'($urandom_range(0, 7));
      a_wdata = $urandom;
      b_wdata = $urandom;
      a_raddr1 = AW'($urandom_range(0, 7));
      a_raddr2 = AW'($urandom);
      b_raddr1 = AW'($urandom_range(0, 7));
      b_raddr2 = AW'($urandom);
      #1;
      g = exp_grant();
      eg = {g == 1, g == 2};
      e1 = '0; e2 = '0; ew = '0; ed = '0; ewe = 1'b0;
      if (g == 1) begin
        e1 = a_raddr1; e2 = a_raddr2; ew = a_waddr; ed = a_wdata;
        ewe = a_we && a_waddr != 0;
      end else if (g == 2) begin
        e1 = b_raddr1; e2 = b_raddr2; ew = b_waddr; ed = b_wdata;
        ewe = b_we && b_waddr != 0;
      end
      n_cmp++;
      if ({a_gnt, b_gnt} !== eg) begin
        n_bad++;
        $display("FAIL rnd_gnt i=%0d got=%b exp=%b", i, {a_gnt, b_gnt}, eg);
      end
      n_cmp++;
      if ({rf_write_enable, rf_read_address_1, rf_read_address_2,
           rf_write_address, rf_write_data} !== {ewe, e1, e2, ew, ed}) begin
        n_bad++;
        $display("FAIL rnd_rf i=%0d got=%b/%0d/%0d/%0d/%h exp=%b/%0d/%0d/%0d/%h",
                 i, rf_write_enable, rf_read_address_1, rf_read_address_2,
                 rf_write_address, rf_write_data, ewe, e1, e2, ew, ed);
      end
      n_cmp++;
      if ({a_rvalid, b_rvalid} !== {exp_av, exp_bv}) begin
        n_bad++;
        $display("FAIL rnd_rvalid i=%0d got=%b exp=%b", i,
                 {a_rvalid, b_rvalid}, {exp_av, exp_bv});
      end
      if (exp_av || exp_bv) begin
        n_cmp++;
        if ({rdata1, rdata2} !== {exp_r1, exp_r2}) begin
          n_bad++;
          $display("FAIL rnd_rdata i=%0d got=%h/%h exp=%h/%h", i,
                   rdata1, rdata2, exp_r1, exp_r2);
        end
      end
      advance(g);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_limit();
    test_zero_write();
    test_read_before_write();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DATA_W, 32, data width of register file ports.
REQ-002 Parameter ADDR_W, 5, register address width.
REQ-003 Parameter MAX_BURST, 8, maximum consecutive cycles one requester may hold a locked grant.
REQ-004 clock  input  1  rising-edge clock; all state changes on this edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a_req, b_req  input  1 each  requester A/B wants one access this cycle.
REQ-007 a_lock, b_lock  input  1 each  requester asks to keep grant next cycle (burst).
REQ-008 a_we, b_we  input  1 each  access includes a write.
REQ-009 a_waddr, b_waddr  input  ADDR_W each  write address.
REQ-010 a_wdata, b_wdata  input  DATA_W each  write data.
REQ-011 a_raddr1, a_raddr2, b_raddr1, b_raddr2  input  ADDR_W each  read addresses.
REQ-012 a_gnt, b_gnt  output  1 each  combinational grant for the current cycle.
REQ-013 a_rvalid, b_rvalid  output  1 each  registered; read data for previous granted access valid.
REQ-014 rdata1, rdata2  output  DATA_W each  shared read data, pass-through of rf_data_out_1/2.
REQ-015 rf_read_address_1, rf_read_address_2, rf_write_address  output  ADDR_W each  register file addresses.
REQ-016 rf_write_data  output  DATA_W  register file write data.
REQ-017 rf_write_enable  output  1  register file write strobe.
REQ-018 rf_data_out_1, rf_data_out_2  input  DATA_W each  register file read ports (registered, 1-cycle latency).

Function
REQ-019 FSM states IDLE, OWN_A, OWN_B; state, priority pointer, burst counter registered.
REQ-020 IDLE: single requester granted; both requesting -> granted to side named by priority pointer (reset: A).
REQ-021 After any non-locked grant, pointer flips to the other requester (round-robin).
REQ-022 Granted with lock=1 -> next state OWN_x; OWN_x grants x unconditionally while x_req=1, ignoring other requester.
REQ-023 OWN_x exits to IDLE when x_lock=0, x_req=0, or burst counter reaches MAX_BURST granted cycles; on exit pointer points to the other requester.
REQ-024 Burst counter: cleared on entry to OWN_x, increments each granted cycle, width ceil(log2(MAX_BURST+1)), never wraps.
REQ-025 At most one of a_gnt, b_gnt high in any cycle; no grant when neither requests.
REQ-026 Granted requester's addresses/data drive rf_* outputs same cycle; no grant -> rf addresses 0, rf_write_data 0.
REQ-027 rf_write_enable = grant & x_we & (x_waddr != 0); writes to address 0 silently dropped, read still performed.
REQ-028 x_rvalid asserted exactly one cycle after each cycle x_gnt=1; rdata1/rdata2 valid only while some rvalid high.
REQ-029 Same-cycle read and write to same address returns pre-write value (register file read-before-write); no forwarding.
REQ-030 a_req deasserted mid-burst in OWN_A: no grant that cycle, return to IDLE, B may win next cycle.

Reset
REQ-031 Reset asserted: state IDLE, pointer A, burst counter 0, a_rvalid=b_rvalid=0, immediately (asynchronous).
REQ-032 While reset high, a_gnt=b_gnt=0 and rf_write_enable=0 regardless of requests.
REQ-033 Reset mid-burst abandons burst; pending rvalid for the cycle before reset not issued.

Verification
REQ-034 After reset, A req raddr1=7, raddr2=31 -> a_gnt same cycle; next cycle a_rvalid=1, rdata1=7, rdata2=31.
REQ-035 A and B both req each cycle, no lock, 6 cycles -> grants alternate A,B,A,B,A,B; rvalid follows each by one cycle.
REQ-036 A req+lock held 12 cycles, B req continuously -> A granted 8 cycles, then B granted, then A.
REQ-037 B writes 0xDEADBEEF to addr 0, then reads addr 0 -> rf_write_enable stays 0; read returns 0.
REQ-038 A writes 0x1234 to addr 5 while reading addr 5 -> rdata1=5 next cycle; following read of 5 returns 0x1234.
REQ-039 Reset pulsed during A burst cycle 3 -> grants and rvalid drop immediately; after release, B-only req granted first cycle.
